// File: rtl/t03_hud_pkg.sv
// rtl/t03_hud_pkg.sv - shared glyph constants, FSM state type and glyph helpers for the HUD writers
//
// Purpose : common definitions for HUD tile writers.
// Contents: GLYPH_BLANK / GLYPH_ZERO / GLYPH_NINE glyph indices,
//           state_t writer FSM encoding,
//           glyph_ok()  - glyph is blank or a digit,
//           glyph_fix() - glyph_ok() ? glyph : blank.
package t03_hud_pkg;

    localparam logic [5:0] GLYPH_BLANK = 6'd3;
    localparam logic [5:0] GLYPH_ZERO  = 6'd26;
    localparam logic [5:0] GLYPH_NINE  = 6'd35;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VB = 2'd1,
        WR_TENS = 2'd2,
        WR_ONES = 2'd3
    } state_t;

    function automatic logic glyph_ok(input logic [5:0] g);
        return (g == GLYPH_BLANK) || ((g >= GLYPH_ZERO) && (g <= GLYPH_NINE));
    endfunction

    function automatic logic [5:0] glyph_fix(input logic [5:0] g);
        return glyph_ok(g) ? g : GLYPH_BLANK;
    endfunction

endpackage

// File: rtl/t03_hud_health_writer.sv
// rtl/t03_hud_health_writer.sv - writes the two health glyphs into the tile buffer during vblank when they change
//
// Purpose : watches the decoded health glyph pair and, whenever it differs
//           from what was last written, writes tens then ones glyph into
//           the tile buffer over a valid/ready handshake inside vblank.
// Ports   : clk        system clock, rising edge
//           nrst       asynchronous active-low reset
//           phealth    [11:6] tens glyph, [5:0] ones glyph
//           vblank     high while tile-buffer writes are permitted
//           wr_valid   tile write request
//           wr_ready   tile buffer accept
//           wr_addr    tile address of the current write
//           wr_data    glyph index of the current write
//           busy       high whenever the FSM is not IDLE
//           done       one-cycle pulse after the ones write is accepted
//           glyph_err  one-cycle pulse after capturing an out-of-range glyph
module t03_hud_health_writer
    import t03_hud_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] TENS_ADDR  = 10'd34,
    parameter logic [ADDR_W-1:0] ONES_ADDR  = 10'd35,
    parameter int                LEAD_BLANK = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [11:0]       phealth,
    input  logic              vblank,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              glyph_err
);

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_snap;
    logic [11:0] r_last;
    logic        r_done;
    logic        r_glyph_err;

    logic        w_change;
    logic        w_hs;
    logic        w_capture;
    logic        w_bad_glyph;
    logic [5:0]  w_tens_glyph;
    logic [5:0]  w_ones_glyph;

    // Change is judged against what actually reached the tile buffer, so a
    // value that wanders and comes back while busy never triggers a write.
    assign w_change    = (phealth != r_last);
    assign w_hs        = wr_valid & wr_ready;
    assign w_capture   = (r_state == IDLE) && w_change;
    assign w_bad_glyph = !glyph_ok(phealth[11:6]) || !glyph_ok(phealth[5:0]);

    // The snapshot keeps the raw glyphs so last_written matches phealth after
    // the write; otherwise a bad glyph would re-trigger a refresh forever.
    always_comb begin
        w_tens_glyph = glyph_fix(r_snap[11:6]);
        if ((LEAD_BLANK != 0) && (w_tens_glyph == GLYPH_ZERO)) begin
            w_tens_glyph = GLYPH_BLANK;
        end
        w_ones_glyph = glyph_fix(r_snap[5:0]);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_snap      <= 12'h000;
            r_last      <= 12'hFFF;
            r_done      <= 1'b0;
            r_glyph_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= (r_state == WR_ONES) && w_hs;
            r_glyph_err <= w_capture && w_bad_glyph;
            if (w_capture) begin
                r_snap <= phealth;
            end
            if ((r_state == WR_ONES) && w_hs) begin
                r_last <= r_snap;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = 6'd0;
        case (r_state)
            IDLE: begin
                if (w_change) begin
                    w_next = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank) begin
                    w_next = WR_TENS;
                end
            end
            // Once a write is offered it stays offered until accepted, even
            // if vblank drops; the tile buffer owns the timing from here.
            WR_TENS: begin
                wr_valid = 1'b1;
                wr_addr  = TENS_ADDR;
                wr_data  = w_tens_glyph;
                if (wr_ready) begin
                    w_next = WR_ONES;
                end
            end
            WR_ONES: begin
                wr_valid = 1'b1;
                wr_addr  = ONES_ADDR;
                wr_data  = w_ones_glyph;
                if (wr_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign glyph_err = r_glyph_err;

endmodule

// File: tb/tb_t03_hud_health_writer.sv
// tb/tb_t03_hud_health_writer.sv - directed self-checking bench for t03_hud_health_writer
module tb_t03_hud_health_writer;

    logic        clk;
    logic        nrst;
    logic [11:0] phealth;
    logic        vblank;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [5:0]  wr_data;
    logic        busy;
    logic        done;
    logic        glyph_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wq[$];

    t03_hud_health_writer dut (
        .clk       (clk),
        .nrst      (nrst),
        .phealth   (phealth),
        .vblank    (vblank),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .glyph_err (glyph_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (nrst && wr_valid && wr_ready) begin
            wq.push_back({wr_addr, wr_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [15:0] wq_at(input int i);
        if (i < wq.size()) return wq[i];
        return 16'hFFFF;
    endfunction

    function automatic logic [15:0] wr_ent(input int addr, input int data);
        logic [9:0] a;
        logic [5:0] d;
        a = addr[9:0];
        d = data[5:0];
        return {a, d};
    endfunction

    task automatic wait_done(input string tag, input int n);
        int seen;
        seen = 0;
        for (int c = 0; c < 200 && seen < n; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, seen, n);
    endtask

    task automatic check_pair(input string tag, input int base, input int tens, input int ones);
        check({tag, "_tens"}, wq_at(base),     wr_ent(34, tens));
        check({tag, "_ones"}, wq_at(base + 1), wr_ent(35, ones));
    endtask

    initial begin
        logic bad_busy;
        logic bad_valid;

        nrst     = 1'b0;
        phealth  = 12'h6DB;
        vblank   = 1'b1;
        wr_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", wr_valid, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gerr", glyph_err, 0);

        // First refresh after reset, exact cycle timing
        nrst = 1'b1;
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_novalid", wr_valid, 0);
        @(negedge clk);
        check("t1_v0", wr_valid, 1);
        check("t1_a0", wr_addr, 34);
        check("t1_d0", wr_data, 27);
        @(negedge clk);
        check("t1_v1", wr_valid, 1);
        check("t1_a1", wr_addr, 35);
        check("t1_d1", wr_data, 27);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_valid_off", wr_valid, 0);
        check("t1_idle", busy, 0);
        check("t1_count", wq.size(), 2);
        check_pair("t1", 0, 27, 27);
        check("t1_gerr", glyph_err, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);

        // Leading zero in tens is blanked, ones nine kept
        wq.delete();
        phealth = 12'h6A3;
        wait_done("t2_done", 1);
        check("t2_count", wq.size(), 2);
        check_pair("t2", 0, 3, 35);

        // Held off by vblank; wander-and-return while busy causes no extra write
        wq.delete();
        vblank  = 1'b0;
        phealth = 12'h71D;
        @(negedge clk);
        bad_busy  = 1'b0;
        bad_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) bad_busy = 1'b1;
            if (wr_valid) bad_valid = 1'b1;
            if (i == 5) phealth = 12'h123;
            if (i == 8) phealth = 12'h71D;
            @(negedge clk);
        end
        check("t3_busy_held", bad_busy, 0);
        check("t3_no_valid", bad_valid, 0);
        vblank = 1'b1;
        @(negedge clk);
        check("t3_start_v", wr_valid, 1);
        check("t3_start_d", wr_data, 28);
        wait_done("t3_done", 1);
        repeat (10) @(negedge clk);
        check("t3_count", wq.size(), 2);
        check_pair("t3", 0, 28, 29);

        // Back-pressure in WR_TENS with phealth changing underneath
        wq.delete();
        wr_ready = 1'b0;
        phealth  = 12'h79F;
        repeat (2) @(negedge clk);
        bad_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!wr_valid || wr_addr != 10'd34 || wr_data != 6'd30) bad_valid = 1'b1;
            if (i == 1) phealth = 12'h821;
            @(negedge clk);
        end
        check("t4_stable", bad_valid, 0);
        wr_ready = 1'b1;
        wait_done("t4_done", 2);
        check("t4_count", wq.size(), 4);
        check_pair("t4_old", 0, 30, 31);
        check_pair("t4_new", 2, 32, 33);

        // Out-of-range ones glyph
        wq.delete();
        phealth = 12'h6E8;
        @(negedge clk);
        check("t5_gerr", glyph_err, 1);
        @(negedge clk);
        check("t5_gerr_pulse", glyph_err, 0);
        wait_done("t5_done", 1);
        check_pair("t5", 0, 27, 3);

        // Reset while in WR_ONES
        phealth = 12'h862;
        repeat (3) @(negedge clk);
        check("t6_in_ones", wr_addr, 35);
        #2 nrst = 1'b0;
        #1;
        check("t6_rst_valid", wr_valid, 0);
        check("t6_rst_addr", wr_addr, 0);
        check("t6_rst_data", wr_data, 0);
        check("t6_rst_busy", busy, 0);
        wq.delete();
        @(negedge clk);
        nrst = 1'b1;
        wait_done("t6_done", 1);
        check("t6_count", wq.size(), 2);
        check_pair("t6", 0, 33, 34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
